seq_pipe_addtree: RTL
=====================

Name: seq_pipe_addtree

Overview:
- Parametrised, elastic, pipelined adder tree. Reduces NIN lanes of W bits to one W-bit sum.
- Next generation of the fixed 4-input, 2-stage, 8-bit pipelined adder.
- Adds parametrised width and lane count, valid/ready backpressure, flush, overflow flag and a wrap/saturate mode.
- Sits between lane-parallel producers and any ready/valid consumer in the datapath.

Parameters:
- NIN, 4, lane count; power of two, >= 2. LEVELS = log2(NIN).
- W, 8, lane and output width in bits; >= 1.
- SAT, 0, overflow mode: 0 = wrap (sum mod 2^W), 1 = unsigned saturate to 2^W-1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline clear.
- in_val  in  1  input transaction valid.
- in_rdy  out  1  block can accept an input this cycle.
- in_data  in  NIN*W  flattened lanes; lane i = in_data[i*W +: W].
- out_val  out  1  out_sum/out_ovf hold a valid result.
- out_rdy  in  1  consumer accepts the result this cycle.
- out_sum  out  W  final sum, wrapped or saturated per SAT.
- out_ovf  out  1  true unsigned sum of all lanes > 2^W-1; reported in both modes.

Behaviour:
- Structure: LEVELS register stages S0..S(LEVELS-1), each with a valid bit v[k].
  - S0 captures the raw lanes.
  - S(k), k >= 1, captures the results of tree level k.
  - The final tree level is combinational from S(LEVELS-1) to out_sum/out_ovf.
- Widths: level-k partial sums are W+k bits, so no intermediate loss. Truncation or saturation is applied only at the final output. out_ovf = any bit above W set in the full (W+LEVELS)-bit total.
- Transfers: input when in_val && in_rdy at a posedge; output when out_val && out_rdy at a posedge.
- Advance rule:
  - adv[LEVELS-1] = !v[LEVELS-1] || out_rdy.
  - adv[k] = !v[k] || adv[k+1].
  - in_rdy = adv[0] && !flush. The combinational ready chain is permitted.
- Stage update: when adv[k], S(k) loads from its upstream source and v[k] takes the upstream valid (in_val && in_rdy for S0). Otherwise S(k) and v[k] hold.
- Latency: a transaction accepted at edge t drives out_val=1 with its sum after edge t+LEVELS-1 (i.e. LEVELS register stages), provided no stall.
- Throughput: one transaction per cycle when out_rdy=1 continuously.
- Ordering: strict FIFO. Every accepted transaction is output exactly once unless flushed.
- Stability: while out_val=1 and out_rdy=0, out_sum and out_ovf hold stable and no stage holding valid data is overwritten.
- Capacity: LEVELS transactions in flight. With out_rdy held low, in_rdy drops after LEVELS acceptances.
- Flush:
  - At a posedge with flush=1, all v[k] clear.
  - Input is not accepted that cycle, since in_rdy=0 during flush.
  - Data registers may keep stale values.
  - Any output handshake in that same cycle still counts as a completed transfer.
- Reset: reset_n=0 immediately clears all v[k] and all data registers. So out_val=0, out_sum=0, out_ovf=0, and in_rdy=1 once flush=0. Reset mid-operation discards all in-flight data. Release is sampled synchronously on the next posedge.
- Wrap example: W=8, total 360 -> out_sum=104, out_ovf=1.
- Saturate example: W=8, total 360 -> out_sum=255, out_ovf=1.
- Boundary: all lanes 2^W-1 -> true total NIN*(2^W-1). The intermediate width must hold this with no loss.

Test Plan:
1. NIN=4, W=8, SAT=0. Reset, then in_data lanes {1,2,3,4}, in_val for 1 cycle, out_rdy=1 -> out_val high exactly one cycle, 2 cycles after acceptance; out_sum=10, out_ovf=0.
2. Stream 6 back-to-back transactions (lanes {k,k,k,k}, k=1..6), out_rdy=1 -> in_rdy stays 1; outputs 4,8,12,16,20,24 on 6 consecutive cycles, in order.
3. Lanes {200,100,50,10}:
   - SAT=0 -> out_sum=104, out_ovf=1.
   - SAT=1 -> out_sum=255, out_ovf=1.
   - Lanes {255,255,255,255} with SAT=1 -> 255, ovf=1.
4. Continuous in_val with increasing data, out_rdy=0 for 5 cycles -> exactly 2 acceptances, then in_rdy=0; out_sum constant while stalled. Raise out_rdy -> both drain in order, then streaming resumes with no loss or duplicate.
5. Two transactions in flight, flush=1 for one cycle with in_val=1 -> that input not accepted; next cycle out_val=0, in_rdy=1; flushed sums never appear. The following new transaction is returned with normal latency.
6. reset_n pulsed low between edges with transactions in flight -> out_val, out_sum and out_ovf go to 0 before the next edge, with no spurious outputs afterwards. Repeat with NIN=8, W=8, SAT=0, all lanes 32 -> out_sum=0, out_ovf=1 at 3-cycle latency.

Source files
------------

// File: rtl/seq_pipe_addtree.sv
// Elastic pipelined adder tree: NIN lanes of W bits reduced to one W-bit sum.
// Result is wrapped or saturated at the output, with a full-precision overflow flag.
module seq_pipe_addtree #(
  parameter int NIN = 4,
  parameter int W   = 8,
  parameter int SAT = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NIN*W-1:0] in_data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [W-1:0]     out_sum,
  output logic             out_ovf
);

  localparam int LEVELS = $clog2(NIN);
  localparam int LAST   = LEVELS - 1;
  localparam int TW     = W + LEVELS;

  logic [LEVELS-1:0] v_reg;
  logic [LEVELS-1:0] v_next;
  logic [LEVELS-1:0] adv;
  logic [TW-1:0]     total;

  // A stage may advance when it or any stage downstream of it has a free slot.
  // Written flat rather than as a chain so no signal depends on itself.
  generate
    for (genvar gi = 0; gi < LEVELS; gi++) begin : g_adv
      assign adv[gi] = out_rdy || !(&v_reg[LEVELS-1:gi]);
    end
  endgenerate

  assign in_rdy  = adv[0] && !flush;
  assign out_val = v_reg[LAST];

  always_comb begin
    v_next = v_reg;
    if (adv[0]) begin
      v_next[0] = in_val && in_rdy;
    end
    for (int k = 1; k < LEVELS; k++) begin
      if (adv[k]) begin
        v_next[k] = v_reg[k-1];
      end
    end
    if (flush) begin
      v_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_reg <= '0;
    end else begin
      v_reg <= v_next;
    end
  end

  // Stage gi holds NIN>>gi partial sums of W+gi bits each, so nothing is lost
  // until the final output.
  generate
    for (genvar gi = 0; gi < LEVELS; gi++) begin : g_stage
      localparam int LW = W + gi;
      localparam int NL = NIN >> gi;

      logic [LW-1:0] lane_reg  [NL];
      logic [LW-1:0] lane_next [NL];

      for (genvar li = 0; li < NL; li++) begin : g_lane
        if (gi == 0) begin : g_in
          assign lane_next[li] = in_data[li*W +: W];
        end else begin : g_add
          assign lane_next[li] = {1'b0, g_stage[gi-1].lane_reg[2*li]}
                               + {1'b0, g_stage[gi-1].lane_reg[2*li+1]};
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < NL; i++) begin
            lane_reg[i] <= '0;
          end
        end else if (adv[gi]) begin
          for (int i = 0; i < NL; i++) begin
            lane_reg[i] <= lane_next[i];
          end
        end
      end
    end
  endgenerate

  // The last tree level is combinational from the final register stage.
  assign total   = {1'b0, g_stage[LAST].lane_reg[0]} + {1'b0, g_stage[LAST].lane_reg[1]};
  assign out_ovf = |total[TW-1:W];

  generate
    if (SAT != 0) begin : g_sat
      assign out_sum = out_ovf ? {W{1'b1}} : total[W-1:0];
    end else begin : g_wrap
      assign out_sum = total[W-1:0];
    end
  endgenerate

endmodule
